// File: rtl/register_file_sb_if.sv
// Decode/writeback bundle for register_file_sb: read ports, writeback port,
// issue port and the hazard/occupancy status that decode stalls on.
interface register_file_sb_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] readAddress1;
    logic [ADDR_WIDTH-1:0] readAddress2;
    logic [DATA_WIDTH-1:0] regData1;
    logic [DATA_WIDTH-1:0] regData2;
    logic [ADDR_WIDTH-1:0] writeAddress;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  regWrite;
    logic                  issueValid;
    logic                  issueWrites;
    logic [ADDR_WIDTH-1:0] issueDest;
    logic                  hazard1;
    logic                  hazard2;
    logic                  wawHazard;
    logic [ADDR_WIDTH:0]   busyCount;

    // Pipeline side: decode drives reads/issue, writeback drives the write port.
    modport master (
        output readAddress1, readAddress2, writeAddress, writeData, regWrite,
               issueValid, issueWrites, issueDest,
        input  regData1, regData2, hazard1, hazard2, wawHazard, busyCount
    );

    // Register file side.
    modport slave (
        input  readAddress1, readAddress2, writeAddress, writeData, regWrite,
               issueValid, issueWrites, issueDest,
        output regData1, regData2, hazard1, hazard2, wawHazard, busyCount
    );
endinterface

// File: rtl/register_file_sb.sv
// 2-read/1-write register file with hardwired zero register, optional
// writeback-to-read bypass, and a busy-bit issue scoreboard for RAW/WAW stalls.
module register_file_sb #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31,
    parameter int BYPASS     = 1
) (
    input logic               clk,
    input logic               reset,
    register_file_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_busy;

    logic                  w_wr_en;
    logic                  w_iss_en;
    logic                  w_byp1;
    logic                  w_byp2;
    logic [DEPTH-1:0]      w_busy_next;
    logic [ADDR_WIDTH:0]   w_busy_count;

    // Qualified write/issue strobes; anything aimed at XZR is dropped.
    assign w_wr_en  = bus.regWrite && (bus.writeAddress != ZERO_ADDR);
    assign w_iss_en = bus.issueValid && bus.issueWrites && (bus.issueDest != ZERO_ADDR);

    // Same-cycle writeback match per read port (only when forwarding is built in).
    assign w_byp1 = (BYPASS != 0) && bus.regWrite && (bus.writeAddress == bus.readAddress1);
    assign w_byp2 = (BYPASS != 0) && bus.regWrite && (bus.writeAddress == bus.readAddress2);

    // Register array: async clear, then writeback.
    // NOTE: the array is cleared in reset because software relies on every
    // register reading 0 after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.writeAddress] <= bus.writeData;
        end
    end

    // Next busy vector: writeback clears first, issue sets last so a new
    // producer issued on the same edge as the old one retires keeps it busy.
    // NOTE: defaulting w_busy_next before the conditional updates keeps this
    // block purely combinational; blocking '=' is right here, '<=' in always_ff.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_en) begin
            w_busy_next[bus.writeAddress] = 1'b0;
        end
        if (w_iss_en) begin
            w_busy_next[bus.issueDest] = 1'b1;
        end
    end

    // Busy vector state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Occupancy: population count of the current busy vector.
    always_comb begin
        w_busy_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_busy_count = w_busy_count + (ADDR_WIDTH + 1)'(r_busy[i]);
        end
    end

    // Read data: XZR first, then forwarded writeback, then stored value.
    always_comb begin
        bus.regData1 = r_regs[bus.readAddress1];
        if (bus.readAddress1 == ZERO_ADDR) begin
            bus.regData1 = '0;
        end else if (w_byp1) begin
            bus.regData1 = bus.writeData;
        end
        bus.regData2 = r_regs[bus.readAddress2];
        if (bus.readAddress2 == ZERO_ADDR) begin
            bus.regData2 = '0;
        end else if (w_byp2) begin
            bus.regData2 = bus.writeData;
        end
    end

    // Hazards: a retiring producer that is forwarded no longer blocks the read;
    // WAW is masked by a same-cycle writeback to the destination.
    assign bus.hazard1 = r_busy[bus.readAddress1] && (bus.readAddress1 != ZERO_ADDR) && !w_byp1;
    assign bus.hazard2 = r_busy[bus.readAddress2] && (bus.readAddress2 != ZERO_ADDR) && !w_byp2;
    assign bus.wawHazard = w_iss_en && r_busy[bus.issueDest]
                           && !(bus.regWrite && (bus.writeAddress == bus.issueDest));
    assign bus.busyCount = w_busy_count;
endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: directed cycles push hand-computed
// expectations; a negedge monitor pops and compares the DUT outputs.
module tb_register_file_sb;
    logic clk;
    logic reset;

    register_file_sb_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

    register_file_sb #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(5),
        .ZERO_REG  (31),
        .BYPASS    (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        string       name;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic        h1;
        logic        h2;
        logic        waw;
        logic [5:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every pushed cycle is compared
    // mid-cycle, well away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".rd1"}, bus.regData1, e.rd1);
                check({e.name, ".rd2"}, bus.regData2, e.rd2);
                check({e.name, ".h1"},  64'(bus.hazard1), 64'(e.h1));
                check({e.name, ".h2"},  64'(bus.hazard2), 64'(e.h2));
                check({e.name, ".waw"}, 64'(bus.wawHazard), 64'(e.waw));
                check({e.name, ".cnt"}, 64'(bus.busyCount), 64'(e.cnt));
            end
        end
    end

    // One cycle of stimulus plus its expected outputs; rst_mid pulses reset
    // high between edges after the inputs are applied.
    task automatic step(
        input string       name,
        input logic [4:0]  ra1, input logic [4:0] ra2,
        input logic        rw,  input logic [4:0] wa, input logic [63:0] wd,
        input logic        iv,  input logic iw, input logic [4:0] id,
        input logic        rst_mid,
        input logic [63:0] e_rd1, input logic [63:0] e_rd2,
        input logic        e_h1, input logic e_h2, input logic e_waw,
        input logic [5:0]  e_cnt
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset            = 1'b0;
        bus.readAddress1 = ra1;
        bus.readAddress2 = ra2;
        bus.regWrite     = rw;
        bus.writeAddress = wa;
        bus.writeData    = wd;
        bus.issueValid   = iv;
        bus.issueWrites  = iw;
        bus.issueDest    = id;
        if (rst_mid) begin
            #2;
            reset = 1'b1;
        end
        e.name = name;
        e.rd1  = e_rd1;
        e.rd2  = e_rd2;
        e.h1   = e_h1;
        e.h2   = e_h2;
        e.waw  = e_waw;
        e.cnt  = e_cnt;
        sb.push_back(e);
    endtask

    initial begin
        reset            = 1'b1;
        bus.readAddress1 = '0;
        bus.readAddress2 = '0;
        bus.regWrite     = 1'b0;
        bus.writeAddress = '0;
        bus.writeData    = '0;
        bus.issueValid   = 1'b0;
        bus.issueWrites  = 1'b0;
        bus.issueDest    = '0;
        repeat (2) @(posedge clk);

        // Post-reset sweep of all 32 addresses.
        for (int k = 0; k < 16; k++) begin
            step("rst_sweep", 5'(2 * k), 5'(2 * k + 1), 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0);
        end

        // Write/bypass/stored path and XZR.
        step("wr3_byp",   3,  0,  1, 3,  64'h1234, 0, 0, 0, 0, 64'h1234, 0, 0, 0, 0, 0);
        step("rd3_stor",  3,  0,  0, 0,  0,        0, 0, 0, 0, 64'h1234, 0, 0, 0, 0, 0);
        step("wr31",      31, 3,  1, 31, 64'hFFFF, 0, 0, 0, 0, 0, 64'h1234, 0, 0, 0, 0);
        step("rd31",      31, 31, 0, 0,  0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // RAW on register 5 and its retirement.
        step("iss5",      5,  3,  0, 0,  0,        1, 1, 5, 0, 0, 64'h1234, 0, 0, 0, 0);
        step("haz5",      5,  5,  0, 0,  0,        0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        step("wb5",       5,  3,  1, 5,  64'h7,    0, 0, 0, 0, 64'h7, 64'h1234, 0, 0, 0, 1);
        step("post_wb5",  5,  5,  0, 0,  0,        0, 0, 0, 0, 64'h7, 64'h7, 0, 0, 0, 0);

        // WAW, then writeback and re-issue of 5 on the same edge.
        step("iss5_a",    5,  0,  0, 0,  0,        1, 1, 5, 0, 64'h7, 0, 0, 0, 0, 0);
        step("iss5_b",    5,  0,  0, 0,  0,        1, 1, 5, 0, 64'h7, 0, 1, 0, 1, 1);
        step("wb_iss5",   5,  4,  1, 5,  64'h99,   1, 1, 5, 0, 64'h99, 0, 0, 0, 0, 1);
        step("still5",    5,  5,  0, 0,  0,        0, 0, 0, 0, 64'h99, 64'h99, 1, 1, 0, 1);
        step("wb5_fin",   5,  5,  1, 5,  64'h55,   0, 0, 0, 0, 64'h55, 64'h55, 0, 0, 0, 1);

        // Non-writing issue, multiple producers, issue to XZR.
        step("iss_nowr",  6,  0,  0, 0,  0,        1, 0, 6, 0, 0, 0, 0, 0, 0, 0);
        step("iss2",      6,  2,  0, 0,  0,        1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        step("iss4",      2,  4,  0, 0,  0,        1, 1, 4, 0, 0, 0, 1, 0, 0, 1);
        step("iss6",      6,  4,  0, 0,  0,        1, 1, 6, 0, 0, 0, 0, 1, 0, 2);
        step("iss31",     6,  2,  0, 0,  0,        1, 1, 31, 0, 0, 0, 1, 1, 0, 3);
        step("busy3",     31, 3,  0, 0,  0,        0, 0, 0, 0, 0, 64'h1234, 0, 0, 0, 3);

        // Async reset between edges with a write to 7 in flight.
        step("async_rst", 6,  3,  1, 7,  64'hAAAA, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("rel_rst",   7,  2,  1, 2,  64'h22,   1, 1, 4, 0, 0, 64'h22, 0, 0, 0, 0);
        step("post_rel",  4,  2,  0, 0,  0,        0, 0, 0, 0, 0, 64'h22, 1, 0, 0, 1);

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 10 && sb.size() > 0; t++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
